// File: rtl/search_arbiter.sv
// Two-requester round-robin front end for a single search engine.
// Optional watchdog in WAIT enabled by defining SEARCH_ARB_TIMEOUT_EN.
module search_arbiter #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic              CLOCK_50,
    input  logic              Reset_n,
    input  logic [1:0]        Req,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] A1,
    output logic [1:0]        Ack,
    output logic              Rsp_Found,
    output logic [ADDR_W-1:0] Rsp_Loc,
    output logic              Rsp_Err,
    output logic              Busy,
    output logic              eng_Init,
    output logic              eng_Start,
    output logic [DATA_W-1:0] eng_A,
    input  logic              eng_Done,
    input  logic              eng_Found,
    input  logic [ADDR_W-1:0] eng_Loc
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   engA_q, engA_d;
    logic                found_q, found_d;
    logic [ADDR_W-1:0]   loc_q, loc_d;
    logic                pickIdx;

`ifdef SEARCH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // With both requesting, the one not served last wins.
    assign pickIdx = (Req == 2'b11) ? ~last_q : Req[1];

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            engA_q  <= '0;
            found_q <= 1'b0;
            loc_q   <= '0;
`ifdef SEARCH_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            engA_q  <= engA_d;
            found_q <= found_d;
            loc_q   <= loc_d;
`ifdef SEARCH_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        engA_d    = engA_q;
        found_d   = found_q;
        loc_d     = loc_q;
`ifdef SEARCH_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        Ack       = 2'b00;
        Rsp_Found = 1'b0;
        Rsp_Loc   = '0;
        Rsp_Err   = 1'b0;
        eng_Init  = 1'b0;
        eng_Start = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req != 2'b00) begin
                    grant_d = pickIdx;
                    engA_d  = pickIdx ? A1 : A0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_Init = 1'b1;
                state_d  = WAIT;
`ifdef SEARCH_ARB_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            WAIT: begin
                eng_Start = 1'b1;
                if (eng_Done) begin
                    found_d = eng_Found;
                    loc_d   = eng_Loc;
`ifdef SEARCH_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef SEARCH_ARB_TIMEOUT_EN
                // The last allowed WAIT cycle ends in a timeout response.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    found_d = 1'b0;
                    loc_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                Ack[grant_q] = 1'b1;
                Rsp_Found    = found_q;
                Rsp_Loc      = loc_q;
`ifdef SEARCH_ARB_TIMEOUT_EN
                Rsp_Err      = err_q;
`endif
                last_d       = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy  = (state_q != IDLE);
    assign eng_A = engA_q;

endmodule

// File: tb/tb_search_arbiter.sv
// Self-checking bench for search_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_search_arbiter;

    localparam int DATA_W         = 8;
    localparam int ADDR_W         = 5;
    localparam int TIMEOUT_CYCLES = 63;

    logic              CLOCK_50;
    logic              Reset_n;
    logic [1:0]        Req;
    logic [DATA_W-1:0] A0, A1;
    logic [1:0]        Ack;
    logic              Rsp_Found;
    logic [ADDR_W-1:0] Rsp_Loc;
    logic              Rsp_Err;
    logic              Busy;
    logic              eng_Init;
    logic              eng_Start;
    logic [DATA_W-1:0] eng_A;
    logic              eng_Done;
    logic              eng_Found;
    logic [ADDR_W-1:0] eng_Loc;

    int vectors     = 0;
    int miscompares = 0;
    int lastServed  = 1;

    search_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .Req(Req), .A0(A0), .A1(A1),
        .Ack(Ack), .Rsp_Found(Rsp_Found), .Rsp_Loc(Rsp_Loc), .Rsp_Err(Rsp_Err),
        .Busy(Busy), .eng_Init(eng_Init), .eng_Start(eng_Start), .eng_A(eng_A),
        .eng_Done(eng_Done), .eng_Found(eng_Found), .eng_Loc(eng_Loc)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Model: single requester wins outright; with both, the one not served last.
    function automatic int pickGrant(input logic [1:0] req);
        if (req == 2'b11) return 1 - lastServed;
        return (req == 2'b10) ? 1 : 0;
    endfunction

    task automatic checkIdle(input string tag);
        check({tag, "_busy"},  32'(Busy), 32'(0));
        check({tag, "_ack"},   32'(Ack), 32'(0));
        check({tag, "_found"}, 32'(Rsp_Found), 32'(0));
        check({tag, "_loc"},   32'(Rsp_Loc), 32'(0));
        check({tag, "_err"},   32'(Rsp_Err), 32'(0));
        check({tag, "_init"},  32'(eng_Init), 32'(0));
        check({tag, "_start"}, 32'(eng_Start), 32'(0));
    endtask

    task automatic doReset();
        Req      = 2'b00;
        eng_Done = 1'b0;
        Reset_n  = 1'b0;
        step();
        step();
        Reset_n    = 1'b1;
        lastServed = 1;
    endtask

    task automatic doTxn(input logic [1:0] req, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] newA0, input logic [7:0] newA1, input int latency,
                         input logic found, input logic [4:0] loc,
                         input bit dropReq, input bit holdReq, input bit noiseDone);
        int         g;
        logic [7:0] key;
        Req = req;
        A0  = a0;
        A1  = a1;
        g   = pickGrant(req);
        key = (g == 1) ? a1 : a0;
        step();
        check("launch_init",  32'(eng_Init), 32'(1));
        check("launch_start", 32'(eng_Start), 32'(0));
        check("launch_busy",  32'(Busy), 32'(1));
        check("launch_key",   32'(eng_A), 32'(key));
        check("launch_ack",   32'(Ack), 32'(0));
        A0 = newA0;
        A1 = newA1;
        if (dropReq) Req = 2'b00;
        if (noiseDone) begin
            eng_Done  = 1'b1;
            eng_Found = 1'($urandom);
            eng_Loc   = 5'($urandom);
        end
        step();
        eng_Done = 1'b0;
        for (int c = 1; c < latency; c++) begin
            check("wait_start", 32'(eng_Start), 32'(1));
            check("wait_init",  32'(eng_Init), 32'(0));
            check("wait_ack",   32'(Ack), 32'(0));
            check("wait_key",   32'(eng_A), 32'(key));
            eng_Found = 1'($urandom);
            eng_Loc   = 5'($urandom);
            step();
        end
        check("wait_last_start", 32'(eng_Start), 32'(1));
        eng_Done  = 1'b1;
        eng_Found = found;
        eng_Loc   = loc;
        step();
        eng_Done  = 1'b0;
        eng_Found = 1'($urandom);
        eng_Loc   = 5'($urandom);
        check("resp_ack",   32'(Ack), 32'(1 << g));
        check("resp_found", 32'(Rsp_Found), 32'(found));
        check("resp_loc",   32'(Rsp_Loc), 32'(loc));
        check("resp_err",   32'(Rsp_Err), 32'(0));
        check("resp_start", 32'(eng_Start), 32'(0));
        check("resp_busy",  32'(Busy), 32'(1));
        check("resp_key",   32'(eng_A), 32'(key));
        lastServed = g;
        if (!holdReq) Req = 2'b00;
        step();
        checkIdle("post_resp");
    endtask

    initial begin
        Req       = 2'b00;
        A0        = '0;
        A1        = '0;
        eng_Done  = 1'b0;
        eng_Found = 1'b0;
        eng_Loc   = '0;
        Reset_n   = 1'b1;
        #2;

        // Reset state
        doReset();
        checkIdle("reset");
        check("reset_key", 32'(eng_A), 32'(0));

        // Single request from requester 0, hit at location 5
        doTxn(2'b01, 8'h03, 8'h00, 8'h03, 8'h00, 6, 1'b1, 5'd5, 0, 0, 0);

        // Requester 1, key changes after grant must be ignored, miss
        doTxn(2'b10, 8'h00, 8'h07, 8'h00, 8'h20, 3, 1'b0, 5'd0, 0, 0, 0);

        // Both requesting continuously from reset: grants alternate 0,1,0,1
        doReset();
        for (int i = 0; i < 4; i++)
            doTxn(2'b11, 8'h11, 8'h22, 8'h11, 8'h22, 2, 1'b1, 5'(i + 9), 0, 1, 0);
        Req = 2'b00;
        step();
        checkIdle("rr_tail");

        // Done in IDLE with no request is ignored
        eng_Done  = 1'b1;
        eng_Found = 1'b1;
        eng_Loc   = 5'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            checkIdle("idle_done");
        end
        eng_Done = 1'b0;

        // Asynchronous reset during WAIT
        Req = 2'b10;
        A1  = 8'h55;
        step();
        step();
        check("prereset_start", 32'(eng_Start), 32'(1));
        Req = 2'b00;
        #2;
        Reset_n = 1'b0;
        #1;
        checkIdle("async_reset");
        check("async_reset_key", 32'(eng_A), 32'(0));
        step();
        Reset_n    = 1'b1;
        lastServed = 1;
        step();
        checkIdle("after_reset");
        doTxn(2'b11, 8'hA0, 8'hA1, 8'hA0, 8'hA1, 4, 1'b1, 5'd17, 0, 0, 0);

`ifdef SEARCH_ARB_TIMEOUT_EN
        // Engine never answers: watchdog response after TIMEOUT_CYCLES WAIT cycles
        begin
            int waited;
            Req = 2'b01;
            A0  = 8'h3C;
            step();
            step();
            Req    = 2'b00;
            waited = 0;
            while (Ack == 2'b00 && waited < TIMEOUT_CYCLES + 10) begin
                step();
                waited++;
            end
            check("timeout_cycles", 32'(waited), 32'(TIMEOUT_CYCLES));
            check("timeout_ack",    32'(Ack), 32'(1));
            check("timeout_err",    32'(Rsp_Err), 32'(1));
            check("timeout_found",  32'(Rsp_Found), 32'(0));
            check("timeout_loc",    32'(Rsp_Loc), 32'(0));
            lastServed = 0;
            step();
            checkIdle("timeout_idle");
        end
`endif

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            doTxn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), $urandom_range(1, 8),
                  1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end
        Req = 2'b00;
        step();
        checkIdle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
